keypad_scanner: RTL and testbench

//  - Front end of the code lock. Scans a 3-column x 4-row matrix keypad, synchronises and debounces the rows, and encodes one key per press.
//  - Emits the 4-bit key code plus a one-cycle valid strobe, which drive the Code_1/Valid_1 inputs of the lock decider directly downstream.
//  - Key encoding: 0-9 = 4'b0000..4'b1001, '*' = 4'b1010, '#' = 4'b1011.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : key codes, scanner FSM states and row/column key encoder
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'b1010;
    localparam logic [3:0] KEY_HASH = 4'b1011;

    typedef enum logic [3:0] {
        ST_SCAN     = 4'b0001,
        ST_DEBOUNCE = 4'b0010,
        ST_PRESSED  = 4'b0100,
        ST_RELEASE  = 4'b1000
    } state_e;

    // row_n is one-cold (active-low row), col is the driven column index
    function automatic logic [3:0] encode(input logic [3:0] row_n, input logic [1:0] col);
        logic [3:0] code;
        code = 4'b0000;
        case (row_n)
            4'b1110: code = 4'd1 + {2'b00, col};
            4'b1101: code = 4'd4 + {2'b00, col};
            4'b1011: code = 4'd7 + {2'b00, col};
            4'b0111: begin
                case (col)
                    2'd0:    code = KEY_STAR;
                    2'd1:    code = 4'b0000;
                    default: code = KEY_HASH;
                endcase
            end
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : two-flop synchroniser for quasi-static asynchronous inputs
// Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter int unsigned    WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 3x4 matrix keypad scanner, debouncer and key encoder
// Revision       : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic       clk,
    input  logic       reset_1,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] Code_1,
    output logic       Valid_1,
    output logic       key_held
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]       row_s;
    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic [3:0]       w_low;
    logic             w_single;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_col_next;

    // Rows idle high, so the synchroniser resets to all-ones to avoid a phantom press
    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (reset_1),
        .d_i   (row_in),
        .q_o   (row_s)
    );

    assign w_low      = ~row_s;
    assign w_single   = (w_low != 4'b0000) && ((w_low & (w_low - 4'b0001)) == 4'b0000);
    assign w_cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign w_col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            cnt_q   <= '0;
            pat_q   <= 4'hF;
            code_q  <= 4'b0000;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        case (state_q)
            ST_SCAN: begin
                if (w_single) begin
                    pat_d   = row_s;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end else if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    col_d = w_col_next;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (row_s != pat_q) begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_PRESSED: begin
                code_d  = encode(pat_q, col_q);
                valid_d = 1'b1;
                held_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Any low row restarts the release window, so other keys are ignored here
                if (row_s != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    held_d  = 1'b0;
                    cnt_d   = '0;
                    col_d   = w_col_next;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SCAN;
            end
        endcase
    end

    always_comb begin
        case (col_q)
            2'd0:    col_out = 3'b110;
            2'd1:    col_out = 3'b101;
            default: col_out = 3'b011;
        endcase
    end

    assign Code_1   = code_q;
    assign Valid_1  = valid_q;
    assign key_held = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed bench with keypad short model and strobe scoreboard
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CYC = 8;

    logic       clk;
    logic       reset_1;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic [3:0] Code_1;
    logic       Valid_1;
    logic       key_held;

    logic [11:0] keys;
    logic [3:0]  exp_q[$];
    int          checks;
    int          errors;
    int          pulses;
    int          cyc;
    int          last_pulse_cyc;
    logic        prev_valid;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk      (clk),
        .reset_1  (reset_1),
        .row_in   (row_in),
        .col_out  (col_out),
        .Code_1   (Code_1),
        .Valid_1  (Valid_1),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // A pressed key shorts its row to its column; rows are pulled up
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Key index k = row*3 + col
    function automatic logic [3:0] key_code(input int k);
        case (k)
            0: return 4'd1;   1: return 4'd2;   2: return 4'd3;
            3: return 4'd4;   4: return 4'd5;   5: return 4'd6;
            6: return 4'd7;   7: return 4'd8;   8: return 4'd9;
            9: return 4'd10;  10: return 4'd0;  default: return 4'd11;
        endcase
    endfunction

    always @(negedge clk) begin
        if (Valid_1) begin
            logic [3:0] exp;
            pulses++;
            last_pulse_cyc = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe: observed code %0d, expected no strobe", Code_1);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                checks++;
                assert (Code_1 === exp) else begin
                    errors++;
                    $error("FAIL strobe_code: observed %0d, expected %0d", Code_1, exp);
                end
            end
            checks++;
            assert (key_held === 1'b1) else begin
                errors++;
                $error("FAIL held_at_strobe: observed %b, expected 1", key_held);
            end
            checks++;
            assert (prev_valid === 1'b0) else begin
                errors++;
                $error("FAIL valid_back_to_back: observed prev %b, expected 0", prev_valid);
            end
        end
        prev_valid = Valid_1;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_col"},   {5'd0, col_out}, 8'h06);
        check_val({tag, "_code"},  {4'd0, Code_1},  8'h00);
        check_val({tag, "_valid"}, {7'd0, Valid_1}, 8'h00);
        check_val({tag, "_held"},  {7'd0, key_held}, 8'h00);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed %0d pending strobes, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (key_held === 1'b0) else begin
            errors++;
            $error("FAIL %s: observed key_held %b, expected 0", tag, key_held);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic press_release(input int k);
        keys[k] = 1'b1;
        exp_q.push_back(key_code(k));
        wait_drain($sformatf("strobe_key%0d", k));
        repeat (5) @(negedge clk);
        keys[k] = 1'b0;
        wait_idle($sformatf("release_key%0d", k));
    endtask

    initial begin
        int p0;
        int n;
        int t_stable;
        checks     = 0;
        errors     = 0;
        pulses     = 0;
        cyc        = 0;
        prev_valid = 1'b0;
        keys       = '0;
        reset_1    = 1'b0;

        // Reset and idle column rotation
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_1 = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rot_col0_hold", {5'd0, col_out}, 8'h06);
        @(negedge clk);
        check_val("rot_col1", {5'd0, col_out}, 8'h05);
        repeat (4) @(negedge clk);
        check_val("rot_col2", {5'd0, col_out}, 8'h03);
        repeat (4) @(negedge clk);
        check_val("rot_wrap", {5'd0, col_out}, 8'h06);

        // Clean press of '5', then release timing of key_held
        keys[4] = 1'b1;
        exp_q.push_back(4'd5);
        wait_drain("strobe_5");
        repeat (30) @(negedge clk);
        check_val("held_5", {7'd0, key_held}, 8'h01);
        check_val("code_hold_5", {4'd0, Code_1}, 8'h05);
        keys[4] = 1'b0;
        repeat (6) @(negedge clk);
        check_val("held_during_release", {7'd0, key_held}, 8'h01);
        repeat (6) @(negedge clk);
        check_val("held_after_release", {7'd0, key_held}, 8'h00);
        repeat (4) @(negedge clk);

        // '*' then '#', followed by full keymap sweep
        press_release(9);
        press_release(11);
        for (int k = 0; k < 12; k++) press_release(k);

        // Bounce on '7'
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            keys[6] = 1'b1;
            repeat (3) @(negedge clk);
            keys[6] = 1'b0;
            repeat (3) @(negedge clk);
        end
        keys[6] = 1'b1;
        t_stable = cyc;
        exp_q.push_back(4'd7);
        wait_drain("strobe_bounce_7");
        check_val("bounce_pulses", 8'(pulses - p0), 8'd1);
        checks++;
        assert ((last_pulse_cyc - t_stable) >= int'(DEBOUNCE_CYC + 2) &&
                (last_pulse_cyc - t_stable) <= int'(DEBOUNCE_CYC + 2 + 3*SCAN_DIV + 6)) else begin
            errors++;
            $error("FAIL bounce_latency: observed %0d cycles, expected %0d..%0d", last_pulse_cyc - t_stable,
                   DEBOUNCE_CYC + 2, DEBOUNCE_CYC + 2 + 3*SCAN_DIV + 6);
        end
        repeat (5) @(negedge clk);
        keys[6] = 1'b0;
        wait_idle("release_bounce_7");

        // Ghosting: '1' and '4' together
        p0 = pulses;
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        repeat (40) @(negedge clk);
        check_val("ghost_no_pulse", 8'(pulses - p0), 8'd0);
        keys[0] = 1'b0;
        keys[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Hold '2', then press '3' as well
        p0 = pulses;
        keys[1] = 1'b1;
        exp_q.push_back(4'd2);
        wait_drain("strobe_hold_2");
        keys[2] = 1'b1;
        repeat (30) @(negedge clk);
        keys[1] = 1'b0;
        keys[2] = 1'b0;
        wait_idle("release_2_3");
        repeat (30) @(negedge clk);
        check_val("hold_one_pulse", 8'(pulses - p0), 8'd1);
        check_val("hold_code", {4'd0, Code_1}, 8'h02);

        // Reset during debounce of '9' (column 2 freshly active)
        n = 0;
        while (col_out !== 3'b101 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (col_out !== 3'b011 && n < 20) begin @(negedge clk); n++; end
        check_val("col2_reached", {5'd0, col_out}, 8'h03);
        p0 = pulses;
        keys[8] = 1'b1;
        repeat (5) @(negedge clk);
        reset_1 = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        check_val("reset_no_pulse", 8'(pulses - p0), 8'd0);
        reset_1 = 1'b1;
        exp_q.push_back(4'd9);
        wait_drain("strobe_9_after_reset");
        repeat (5) @(negedge clk);
        keys[8] = 1'b0;
        wait_idle("release_9");
        check_val("reset_one_pulse", 8'(pulses - p0), 8'd1);

        repeat (20) @(negedge clk);
        check_val("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
